instr_fetch_unit: RTL and testbench

Instruction fetch stage for the multicycle RV32 core: holds the architectural PC, fetches from instruction memory over a req/ack handshake, and buffers the returned word. Sits directly upstream of the control FSM, supplying it `opcode`, `funct3` and `funct7_bit5` from the instruction register. It consumes the control FSM's `pcwrite`, `irwrite` and the datapath result bus (next PC).

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/instr_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared RV32 encodings used by the fetch stage and control FSM.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Multicycle RV32 fetch stage: PC, req/ack fetch, IR and decode.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        irwrite,
    input  logic        pcwrite,
    input  logic [31:0] pc_next,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7_bit5,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        instr_ready,
    output logic        pc_misaligned,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_READY = 2'd2
    } fetch_state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    fetch_state_e state_q, state_d;
    logic         req_q, req_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  old_pc_q, old_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  fetch_buf_q, fetch_buf_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         misaligned_q, misaligned_d;
    logic         fault_q, fault_d;
    logic [7:0]   cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        req_addr_d   = req_addr_q;
        pc_d         = pc_q;
        old_pc_d     = old_pc_q;
        instr_d      = instr_q;
        fetch_buf_d  = fetch_buf_q;
        cnt_d        = cnt_q;
        misaligned_d = misaligned_q;
        fault_d      = fault_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_en) begin
                    req_addr_d = pc_q;
                    req_d      = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    fetch_buf_d = imem_rdata;
                    req_d       = 1'b0;
                    state_d     = S_READY;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    cnt_d   = cnt_inc;
                    fault_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_READY: begin
                if (irwrite) begin
                    instr_d  = fetch_buf_q;
                    old_pc_d = req_addr_q;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // PC updates are independent of the fetch handshake; req_addr is untouched.
        if (pcwrite) begin
            pc_d = {pc_next[31:2], 2'b00};
            if (!is_word_aligned(pc_next)) begin
                misaligned_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            req_addr_q   <= RESET_PC;
            pc_q         <= RESET_PC;
            old_pc_q     <= RESET_PC;
            instr_q      <= NOP_INSTR;
            fetch_buf_q  <= 32'h0000_0000;
            cnt_q        <= 8'd0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_addr_q   <= req_addr_d;
            pc_q         <= pc_d;
            old_pc_q     <= old_pc_d;
            instr_q      <= instr_d;
            fetch_buf_q  <= fetch_buf_d;
            cnt_q        <= cnt_d;
            misaligned_q <= misaligned_d;
            fault_q      <= fault_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = req_addr_q;
    assign pc            = pc_q;
    assign old_pc        = old_pc_q;
    assign instr         = instr_q;
    assign instr_ready   = (state_q == S_READY);
    assign pc_misaligned = misaligned_q;
    assign fetch_fault   = fault_q;

    assign opcode      = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7_bit5 = instr_q[30];
    assign rs1         = instr_q[19:15];
    assign rs2         = instr_q[24:20];
    assign rd          = instr_q[11:7];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit (transaction-level model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (default parameters)
    logic        fetch_en, irwrite, pcwrite, imem_ack;
    logic [31:0] pc_next, imem_rdata;
    logic        imem_req, funct7_bit5, instr_ready, pc_misaligned, fetch_fault;
    logic [31:0] imem_addr, pc, old_pc, instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;

    // short-timeout instance
    logic        t_fetch_en, t_irwrite, t_pcwrite, t_imem_ack;
    logic [31:0] t_pc_next, t_imem_rdata;
    logic        t_imem_req, t_funct7_bit5, t_instr_ready, t_pc_misaligned, t_fetch_fault;
    logic [31:0] t_imem_addr, t_pc, t_old_pc, t_instr;
    logic [6:0]  t_opcode;
    logic [2:0]  t_funct3;
    logic [4:0]  t_rs1, t_rs2, t_rd;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .irwrite(irwrite),
        .pcwrite(pcwrite), .pc_next(pc_next), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
        .pc(pc), .old_pc(old_pc), .instr(instr), .opcode(opcode),
        .funct3(funct3), .funct7_bit5(funct7_bit5), .rs1(rs1), .rs2(rs2),
        .rd(rd), .instr_ready(instr_ready), .pc_misaligned(pc_misaligned),
        .fetch_fault(fetch_fault)
    );

    instr_fetch_unit #(.RESET_PC(32'h0000_0100), .TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .fetch_en(t_fetch_en), .irwrite(t_irwrite),
        .pcwrite(t_pcwrite), .pc_next(t_pc_next), .imem_ack(t_imem_ack),
        .imem_rdata(t_imem_rdata), .imem_req(t_imem_req), .imem_addr(t_imem_addr),
        .pc(t_pc), .old_pc(t_old_pc), .instr(t_instr), .opcode(t_opcode),
        .funct3(t_funct3), .funct7_bit5(t_funct7_bit5), .rs1(t_rs1), .rs2(t_rs2),
        .rd(t_rd), .instr_ready(t_instr_ready), .pc_misaligned(t_pc_misaligned),
        .fetch_fault(t_fetch_fault)
    );

    int n_total = 0;
    int n_pass  = 0;

    // architectural expectations for the main instance
    logic [31:0] m_pc, m_old_pc, m_instr;
    logic        m_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        fetch_en     = 1'b0;
        irwrite      = 1'b0;
        pcwrite      = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = $urandom;
        pc_next      = $urandom;
        t_fetch_en   = 1'b0;
        t_irwrite    = 1'b0;
        t_imem_ack   = 1'b0;
        t_imem_rdata = $urandom;
    endtask

    task automatic pcw(input logic [31:0] v);
        pcwrite = 1'b1;
        pc_next = v;
        m_pc    = {v[31:2], 2'b00};
        if (v[1:0] != 2'b00) m_mis = 1'b1;
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_old_pc = 32'h0;
        m_instr  = 32'h0000_0013;
        m_mis    = 1'b0;
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".old_pc"}, old_pc, m_old_pc);
        chk({tag, ".instr"}, instr, m_instr);
        chk1({tag, ".mis"}, pc_misaligned, m_mis);
        chk1({tag, ".fault"}, fetch_fault, 1'b0);
    endtask

    task automatic chk_decode(input logic [31:0] w);
        chk("opcode", 32'(opcode), 32'(w[6:0]));
        chk("funct3", 32'(funct3), 32'(w[14:12]));
        chk1("funct7_bit5", funct7_bit5, w[30]);
        chk("rs1", 32'(rs1), 32'(w[19:15]));
        chk("rs2", 32'(rs2), 32'(w[24:20]));
        chk("rd", 32'(rd), 32'(w[11:7]));
    endtask

    // One complete fetch transaction on the main instance.
    task automatic fetch(input int waits, input logic [31:0] word, input int pcw_k,
                         input logic [31:0] pcw_v, input bit pcw_on_fetch,
                         input bit pcw_with_ir, input int hold);
        logic [31:0] exp_addr;
        exp_addr = m_pc;
        fetch_en = 1'b1;
        if (pcw_on_fetch) pcw($urandom & 32'hFFFF_FFFC);
        step();
        chk1("req_rise", imem_req, 1'b1);
        chk("req_addr", imem_addr, exp_addr);
        chk1("ready_early", instr_ready, 1'b0);
        chk("pc_fetch", pc, m_pc);
        for (int k = 0; k <= waits; k++) begin
            if (k == pcw_k) pcw(pcw_v);
            fetch_en = 1'($urandom_range(0, 1));
            irwrite  = 1'($urandom_range(0, 1));
            if (k == waits) begin
                imem_ack   = 1'b1;
                imem_rdata = word;
            end
            step();
            chk("pc_req", pc, m_pc);
            chk1("mis_req", pc_misaligned, m_mis);
            if (k < waits) begin
                chk1("req_hold", imem_req, 1'b1);
                chk("addr_stable", imem_addr, exp_addr);
                chk1("ready_wait", instr_ready, 1'b0);
                chk("instr_wait", instr, m_instr);
            end else begin
                chk1("ready_rise", instr_ready, 1'b1);
                chk1("req_fall", imem_req, 1'b0);
            end
        end
        for (int h = 0; h < hold; h++) begin
            imem_ack = 1'b1;
            fetch_en = 1'($urandom_range(0, 1));
            step();
            chk1("ready_hold", instr_ready, 1'b1);
            chk1("req_hold0", imem_req, 1'b0);
            chk("instr_hold", instr, m_instr);
        end
        irwrite = 1'b1;
        if (pcw_with_ir) pcw($urandom & 32'hFFFF_FFFC);
        step();
        m_instr  = word;
        m_old_pc = exp_addr;
        chk_arch("ir");
        chk1("ready_fall", instr_ready, 1'b0);
        chk_decode(word);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        fetch_en = 0; irwrite = 0; pcwrite = 0; imem_ack = 0;
        pc_next = 0; imem_rdata = 0;
        t_fetch_en = 0; t_irwrite = 0; t_pcwrite = 0; t_imem_ack = 0;
        t_pc_next = 0; t_imem_rdata = 0;
        model_reset();

        // reset values
        step();
        step();
        chk_arch("reset");
        chk("reset.addr", imem_addr, 32'h0);
        chk1("reset.req", imem_req, 1'b0);
        chk1("reset.ready", instr_ready, 1'b0);
        chk("reset.opcode", 32'(opcode), 32'h13);
        chk_decode(32'h0000_0013);
        chk("t_reset.pc", t_pc, 32'h100);
        chk("t_reset.addr", t_imem_addr, 32'h100);
        chk("t_reset.old_pc", t_old_pc, 32'h100);
        reset = 1'b1;
        step();

        // zero-wait fetch
        fetch(0, 32'h0050_0093, -1, 32'h0, 1'b0, 1'b0, 0);
        chk("zw.rd", 32'(rd), 32'd1);
        chk("zw.old_pc", old_pc, 32'h0);

        // five wait states
        fetch(5, $urandom, -1, 32'h0, 1'b0, 1'b0, 0);

        // pcwrite while the request is in flight
        fetch(3, $urandom, 1, 32'h40, 1'b0, 1'b0, 0);
        chk("preq.pc", pc, 32'h40);
        chk("preq.old_pc", old_pc, 32'h0);

        // pcwrite together with irwrite: old_pc takes the fetch address
        fetch(1, $urandom, -1, 32'h0, 1'b0, 1'b1, 1);
        chk("pir.old_pc", old_pc, 32'h40);

        // randomized transactions with idle-time noise
        for (int i = 0; i < 20; i++) begin
            fetch($urandom_range(0, 6), $urandom, $urandom_range(0, 8),
                  $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                imem_ack = 1'b1;
                irwrite  = 1'b1;
                step();
                chk("idle.instr", instr, m_instr);
                chk1("idle.ready", instr_ready, 1'b0);
                chk1("idle.req", imem_req, 1'b0);
            end
        end

        // misaligned next PC is truncated and latched
        pcw(32'h46);
        step();
        chk("mis.pc", pc, 32'h44);
        chk1("mis.flag", pc_misaligned, 1'b1);
        for (int i = 0; i < 4; i++) begin
            fetch($urandom_range(0, 3), $urandom, $urandom_range(0, 4),
                  $urandom & 32'hFFFF_FFFC, 1'b0, 1'($urandom_range(0, 1)), 0);
        end
        chk1("mis.sticky", pc_misaligned, 1'b1);

        // reset in the middle of a request; late ack must be ignored
        fetch_en = 1'b1;
        step();
        chk1("mr.req", imem_req, 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        model_reset();
        chk1("mr.req0", imem_req, 1'b0);
        imem_ack = 1'b1;
        step();
        chk1("mr.late_ready", instr_ready, 1'b0);
        chk1("mr.late_req", imem_req, 1'b0);
        irwrite = 1'b1;
        step();
        chk_arch("mr");

        // timeout instance: no ack for four REQ cycles
        t_fetch_en = 1'b1;
        step();
        chk1("to.req", t_imem_req, 1'b1);
        chk("to.addr", t_imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("to.req_wait", t_imem_req, 1'b1);
            chk1("to.no_fault", t_fetch_fault, 1'b0);
        end
        step();
        chk1("to.fault", t_fetch_fault, 1'b1);
        chk1("to.req0", t_imem_req, 1'b0);
        chk1("to.ready0", t_instr_ready, 1'b0);
        t_imem_ack = 1'b1;
        step();
        chk1("to.late_ready", t_instr_ready, 1'b0);
        t_irwrite = 1'b1;
        step();
        chk("to.instr", t_instr, 32'h0000_0013);

        // ack in the last permitted cycle still completes the fetch
        t_fetch_en = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        chk1("to.edge_req", t_imem_req, 1'b1);
        t_imem_ack   = 1'b1;
        t_imem_rdata = 32'h00A5_8633;
        step();
        chk1("to.edge_ready", t_instr_ready, 1'b1);
        chk1("to.fault_sticky", t_fetch_fault, 1'b1);
        t_irwrite = 1'b1;
        step();
        chk("to.edge_instr", t_instr, 32'h00A5_8633);
        chk("to.edge_old_pc", t_old_pc, 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
